fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage placed directly upstream of the asynchronous instruction ROM. Holds the program counter and drives the ROM word address and read enable. Captures the ROM's combinational instruction word into a registered fetch/decode output. Supports stall, branch/jump redirect, bubble insertion and a sticky trap on illegal fetch addresses.

## Interface
Parameters:
- TAM_POSICIONES, 1024, number of 32-bit words in the instruction ROM; must be a power of two.
- TAM_PALABRA, 32, instruction width in bits.
- RESET_PC, 32'h0000_0000, byte address fetched first after reset; must be word-aligned and in range.
- NOP_INSTR, 32'h0000_0013, instruction emitted on bubbles (addi x0,x0,0).

Ports (AW = $clog2(TAM_POSICIONES)):
- CLK  in  1  single clock; all state changes on the rising edge.
- RST_n  in  1  reset; asynchronous and active-low.
- STALL  in  1  downstream cannot accept; hold PC and IF outputs.
- BRANCH_TAKEN  in  1  redirect request, valid for one cycle.
- BRANCH_TARGET  in  32  byte address of the redirect.
- INS_ADDRESS  out  AW  ROM word address, equal to PC[AW+1:2]; combinational from PC.
- READ_EN  out  1  ROM read enable.
- INSTRUCTION_IN  in  TAM_PALABRA  ROM data; valid in the same cycle as INS_ADDRESS.
- IF_PC  out  32  byte address of IF_INSTR.
- IF_INSTR  out  TAM_PALABRA  registered instruction to decode.
- IF_VALID  out  1  IF_INSTR is a real fetched instruction, not a bubble.
- FETCH_ERR  out  1  sticky trap flag.
- FETCH_COUNT  out  32  number of valid instructions delivered since reset.

## Operation
- States: BOOT, FETCH, HOLD, TRAP.
- BOOT: entered on reset and lasts one cycle.
  - READ_EN=0; PC=RESET_PC.
  - Moves to FETCH on the next edge.
- FETCH: READ_EN=1. At each edge:
  - If BRANCH_TAKEN: check BRANCH_TARGET.
    - If the target is legal: PC<=BRANCH_TARGET; the IF register loads a bubble.
    - If the target is illegal: go to TRAP.
  - Else if STALL: go to HOLD; PC and IF register unchanged.
  - Else: IF_PC<=PC, IF_INSTR<=INSTRUCTION_IN, IF_VALID<=1, PC<=PC+4, FETCH_COUNT+=1.
  - Bubble means IF_INSTR<=NOP_INSTR, IF_VALID<=0, IF_PC<=PC.
- HOLD: READ_EN=1 and INS_ADDRESS stays stable. At each edge:
  - BRANCH_TAKEN: handled exactly as in FETCH; the next state is FETCH or TRAP.
  - Else if STALL: stay in HOLD.
  - Else: perform a normal FETCH capture and return to FETCH.
- Priority: BRANCH_TAKEN > STALL > sequential advance.
- A legal address is word-aligned (bits[1:0]=0) and in range (bits[31:AW+2]=0).
- PC advance: PC+4 uses 32-bit wrapping arithmetic.
  - If PC+4 leaves the ROM range, the next state is TRAP instead of updating the PC.
  - Example: PC=4*TAM_POSICIONES-4 traps rather than wrapping to 0.
- TRAP: READ_EN=0, FETCH_ERR=1, IF_VALID=0, IF_INSTR=NOP_INSTR. PC holds the last legal value.
  - Only RST_n exits TRAP; STALL and BRANCH_TAKEN are ignored.
- FETCH_COUNT wraps modulo 2^32.

## Timing
- Reset values while RST_n=0, applied asynchronously:
  - State BOOT, PC=RESET_PC, READ_EN=0, INS_ADDRESS=RESET_PC[AW+1:2].
  - IF_PC=0, IF_INSTR=NOP_INSTR, IF_VALID=0, FETCH_ERR=0, FETCH_COUNT=0.
- Reset deassertion is synchronous to CLK by integration contract.
  - First edge after deassertion: BOOT→FETCH.
  - Second edge: the first instruction (at RESET_PC) appears on IF_*.
- Latency: one cycle from INS_ADDRESS presentation to IF_INSTR.
  - INSTRUCTION_IN is sampled at the edge that ends the cycle in which INS_ADDRESS was driven.
- Throughput: one instruction per cycle with no stalls.
- Redirect: BRANCH_TAKEN high at edge N.
  - Edge N: bubble on IF_*.
  - Edge N+1: instruction at BRANCH_TARGET on IF_*.
- Stall: IF_* is bit-for-bit stable for every cycle STALL is high; no instruction is lost or duplicated.
- Reset asserted mid-operation in any state returns immediately to the reset values above.

## Test plan
- Reset/boot: RST_n low for 3 cycles, then high; ROM[i]=i+1 → IF_VALID rises at edge 2 with IF_PC=0, IF_INSTR=1; then IF_PC=4, IF_INSTR=2; FETCH_COUNT=2 after edge 3.
- Stall: assert STALL for 3 cycles while IF_PC=8 → IF_PC=8 and IF_INSTR=3 stable for all 3 cycles; after release, IF_PC=12 follows, with no skipped or duplicated instruction.
- Redirect: BRANCH_TAKEN=1, BRANCH_TARGET=0x40 at PC=0x10 → bubble (IF_VALID=0, IF_INSTR=0x13), then IF_PC=0x40, IF_INSTR=17.
- Branch during stall: in HOLD, STALL=1 and BRANCH_TAKEN=1 with target 0x20 → redirect wins; bubble, then IF_PC=0x20 once STALL drops.
- Misaligned target: BRANCH_TARGET=0x22 → TRAP; FETCH_ERR=1 and READ_EN=0 hold for 10 cycles regardless of inputs; RST_n pulse clears them.
- Range end: with TAM_POSICIONES=16, run sequentially from 0 → last valid IF_PC=0x3C, then TRAP; FETCH_COUNT=16.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the asynchronous ROM and registers the fetched word.
// Supports stall, branch redirect with a one-cycle bubble, and a sticky trap on illegal fetch addresses.
module fetch_unit #(
    parameter int                     TAM_POSICIONES = 1024,
    parameter int                     TAM_PALABRA    = 32,
    parameter logic [31:0]            RESET_PC       = 32'h0000_0000,
    parameter logic [TAM_PALABRA-1:0] NOP_INSTR      = TAM_PALABRA'(32'h0000_0013),
    localparam int                    AW             = $clog2(TAM_POSICIONES)
) (
    input  logic                   CLK,
    input  logic                   RST_n,
    input  logic                   STALL,
    input  logic                   BRANCH_TAKEN,
    input  logic [31:0]            BRANCH_TARGET,
    output logic [AW-1:0]          INS_ADDRESS,
    output logic                   READ_EN,
    input  logic [TAM_PALABRA-1:0] INSTRUCTION_IN,
    output logic [31:0]            IF_PC,
    output logic [TAM_PALABRA-1:0] IF_INSTR,
    output logic                   IF_VALID,
    output logic                   FETCH_ERR,
    output logic [31:0]            FETCH_COUNT
);

    typedef enum logic [1:0] {S_BOOT, S_FETCH, S_HOLD, S_TRAP} state_t;

    state_t                 r_state;
    logic [31:0]            r_pc;
    logic                   r_read_en;
    logic [31:0]            r_if_pc;
    logic [TAM_PALABRA-1:0] r_if_instr;
    logic                   r_if_valid;
    logic                   r_fetch_err;
    logic [31:0]            r_fetch_count;

    logic [31:0]            w_pc_plus4;
    logic                   w_target_ok;
    logic                   w_next_ok;

    // Legal means word-aligned and entirely inside the ROM window.
    function automatic logic isLegal(input logic [31:0] addr);
        return (addr[1:0] == 2'b00) && ((addr >> (AW + 2)) == 32'd0);
    endfunction

    assign w_pc_plus4  = r_pc + 32'd4;
    assign w_target_ok = isLegal(BRANCH_TARGET);
    assign w_next_ok   = isLegal(w_pc_plus4);

    assign INS_ADDRESS = r_pc[AW+1:2];
    assign READ_EN     = r_read_en;
    assign IF_PC       = r_if_pc;
    assign IF_INSTR    = r_if_instr;
    assign IF_VALID    = r_if_valid;
    assign FETCH_ERR   = r_fetch_err;
    assign FETCH_COUNT = r_fetch_count;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state       <= S_BOOT;
            r_pc          <= RESET_PC;
            r_read_en     <= 1'b0;
            r_if_pc       <= 32'd0;
            r_if_instr    <= NOP_INSTR;
            r_if_valid    <= 1'b0;
            r_fetch_err   <= 1'b0;
            r_fetch_count <= 32'd0;
        end else begin
            case (r_state)
                S_BOOT: begin
                    r_state   <= S_FETCH;
                    r_read_en <= 1'b1;
                end
                S_FETCH, S_HOLD: begin
                    if (BRANCH_TAKEN) begin
                        if (w_target_ok) begin
                            r_pc       <= BRANCH_TARGET;
                            r_if_pc    <= r_pc;
                            r_if_instr <= NOP_INSTR;
                            r_if_valid <= 1'b0;
                            r_state    <= S_FETCH;
                        end else begin
                            r_state     <= S_TRAP;
                            r_read_en   <= 1'b0;
                            r_fetch_err <= 1'b1;
                            r_if_instr  <= NOP_INSTR;
                            r_if_valid  <= 1'b0;
                        end
                    end else if (STALL) begin
                        r_state <= S_HOLD;
                    end else begin
                        // The last word is still delivered; only the PC refuses to leave the ROM.
                        r_if_pc       <= r_pc;
                        r_if_instr    <= INSTRUCTION_IN;
                        r_if_valid    <= 1'b1;
                        r_fetch_count <= r_fetch_count + 32'd1;
                        if (w_next_ok) begin
                            r_pc    <= w_pc_plus4;
                            r_state <= S_FETCH;
                        end else begin
                            r_state     <= S_TRAP;
                            r_read_en   <= 1'b0;
                            r_fetch_err <= 1'b1;
                        end
                    end
                end
                S_TRAP: begin
                    r_read_en   <= 1'b0;
                    r_fetch_err <= 1'b1;
                    r_if_instr  <= NOP_INSTR;
                    r_if_valid  <= 1'b0;
                end
                default: r_state <= S_BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a 1024-word ROM instance for the main flows and a
// 16-word instance for the end-of-ROM trap. Both ROMs hold ROM[i] = i + 1.
module tb_fetch_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic [31:0] count;
    } exp_t;

    logic        CLK = 1'b0;
    logic        rstA_n, rstB_n;
    logic        stallA, branchA;
    logic [31:0] targetA;
    logic        stallB, branchB;
    logic [31:0] targetB;

    logic [9:0]  insAddrA;
    logic        readEnA;
    logic [31:0] instrInA, ifPcA, ifInstrA, fetchCountA;
    logic        ifValidA, fetchErrA;

    logic [3:0]  insAddrB;
    logic        readEnB;
    logic [31:0] instrInB, ifPcB, ifInstrB, fetchCountB;
    logic        ifValidB, fetchErrB;

    exp_t        gotA, gotB, e;
    exp_t        sbq[$];
    int          errors = 0;
    int          checks = 0;

    assign instrInA = {22'd0, insAddrA} + 32'd1;
    assign instrInB = {28'd0, insAddrB} + 32'd1;
    assign gotA     = {ifPcA, ifInstrA, ifValidA, fetchCountA};
    assign gotB     = {ifPcB, ifInstrB, ifValidB, fetchCountB};

    always #5 CLK = ~CLK;

    fetch_unit #(.TAM_POSICIONES(1024)) dutA (
        .CLK(CLK), .RST_n(rstA_n), .STALL(stallA), .BRANCH_TAKEN(branchA),
        .BRANCH_TARGET(targetA), .INS_ADDRESS(insAddrA), .READ_EN(readEnA),
        .INSTRUCTION_IN(instrInA), .IF_PC(ifPcA), .IF_INSTR(ifInstrA),
        .IF_VALID(ifValidA), .FETCH_ERR(fetchErrA), .FETCH_COUNT(fetchCountA)
    );

    fetch_unit #(.TAM_POSICIONES(16)) dutB (
        .CLK(CLK), .RST_n(rstB_n), .STALL(stallB), .BRANCH_TAKEN(branchB),
        .BRANCH_TARGET(targetB), .INS_ADDRESS(insAddrB), .READ_EN(readEnB),
        .INSTRUCTION_IN(instrInB), .IF_PC(ifPcB), .IF_INSTR(ifInstrB),
        .IF_VALID(ifValidB), .FETCH_ERR(fetchErrB), .FETCH_COUNT(fetchCountB)
    );

    task automatic pushExp(input logic [31:0] pc, input logic [31:0] instr,
                           input logic valid, input logic [31:0] count);
        sbq.push_back('{pc: pc, instr: instr, valid: valid, count: count});
    endtask

    task automatic test_reset;
        rstA_n = 1'b0; stallA = 1'b0; branchA = 1'b0; targetA = 32'd0;
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if ({ifValidA, ifInstrA, ifPcA, fetchErrA, fetchCountA, readEnA, insAddrA} !==
            {1'b0, 32'h13, 32'h0, 1'b0, 32'h0, 1'b0, 10'd0}) begin
            errors++;
            $display("[TB] FAIL reset_values: got valid=%b instr=%h pc=%h err=%b count=%0d rd=%b addr=%0d, expected 0/13/0/0/0/0/0",
                     ifValidA, ifInstrA, ifPcA, fetchErrA, fetchCountA, readEnA, insAddrA);
        end
        @(negedge CLK) rstA_n = 1'b1;
        @(posedge CLK); #1;
        checks++;
        if ({readEnA, ifValidA} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL boot_edge: got rd=%b valid=%b, expected rd=1 valid=0", readEnA, ifValidA);
        end
        pushExp(32'h0, 32'd1, 1'b1, 32'd1);
        pushExp(32'h4, 32'd2, 1'b1, 32'd2);
        repeat (2) begin
            @(posedge CLK); #1;
            e = sbq.pop_front();
            checks++;
            if (gotA !== e) begin
                errors++;
                $display("[TB] FAIL first_fetch: got %h, expected %h", gotA, e);
            end
        end
    endtask

    task automatic test_stall;
        pushExp(32'h8, 32'd3, 1'b1, 32'd3);
        @(posedge CLK); #1;
        e = sbq.pop_front();
        checks++;
        if (gotA !== e) begin
            errors++;
            $display("[TB] FAIL pre_stall: got %h, expected %h", gotA, e);
        end
        stallA = 1'b1;
        repeat (3) pushExp(32'h8, 32'd3, 1'b1, 32'd3);
        repeat (3) begin
            @(posedge CLK); #1;
            e = sbq.pop_front();
            checks++;
            if (gotA !== e || insAddrA !== 10'd3 || readEnA !== 1'b1) begin
                errors++;
                $display("[TB] FAIL stall_hold: got %h addr=%0d rd=%b, expected %h addr=3 rd=1",
                         gotA, insAddrA, readEnA, e);
            end
        end
        stallA = 1'b0;
        pushExp(32'hC, 32'd4, 1'b1, 32'd4);
        @(posedge CLK); #1;
        e = sbq.pop_front();
        checks++;
        if (gotA !== e) begin
            errors++;
            $display("[TB] FAIL stall_release: got %h, expected %h", gotA, e);
        end
    endtask

    task automatic test_redirect;
        branchA = 1'b1; targetA = 32'h40;
        pushExp(32'h10, 32'h13, 1'b0, 32'd4);
        pushExp(32'h40, 32'd17, 1'b1, 32'd5);
        for (int i = 0; i < 2; i++) begin
            @(posedge CLK); #1;
            branchA = 1'b0;
            e = sbq.pop_front();
            checks++;
            if (gotA !== e) begin
                errors++;
                $display("[TB] FAIL redirect_%0d: got %h, expected %h", i, gotA, e);
            end
        end
    endtask

    task automatic test_branch_during_stall;
        stallA = 1'b1;
        pushExp(32'h40, 32'd17, 1'b1, 32'd5);
        pushExp(32'h44, 32'h13, 1'b0, 32'd5);
        pushExp(32'h44, 32'h13, 1'b0, 32'd5);
        pushExp(32'h20, 32'd9, 1'b1, 32'd6);
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK); #1;
            e = sbq.pop_front();
            checks++;
            if (gotA !== e) begin
                errors++;
                $display("[TB] FAIL branch_in_hold_%0d: got %h, expected %h", i, gotA, e);
            end
            branchA = (i == 0);
            targetA = 32'h20;
            stallA  = (i < 2);
        end
    endtask

    task automatic test_misaligned;
        branchA = 1'b1; targetA = 32'h22;
        pushExp(32'h20, 32'h13, 1'b0, 32'd6);
        for (int i = 0; i < 11; i++) begin
            @(posedge CLK); #1;
            e = sbq.pop_front();
            checks++;
            if (gotA !== e || fetchErrA !== 1'b1 || readEnA !== 1'b0 || insAddrA !== 10'd9) begin
                errors++;
                $display("[TB] FAIL trap_%0d: got %h err=%b rd=%b addr=%0d, expected %h err=1 rd=0 addr=9",
                         i, gotA, fetchErrA, readEnA, insAddrA, e);
            end
            stallA  = 1'($urandom_range(0, 1));
            branchA = 1'($urandom_range(0, 1));
            targetA = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            pushExp(32'h20, 32'h13, 1'b0, 32'd6);
        end
        void'(sbq.pop_back());
        stallA = 1'b0; branchA = 1'b0;
        @(negedge CLK) rstA_n = 1'b0;
        #1;
        checks++;
        if ({fetchErrA, readEnA, ifValidA, fetchCountA, ifPcA, insAddrA} !== {3'b000, 32'd0, 32'd0, 10'd0}) begin
            errors++;
            $display("[TB] FAIL trap_reset: got err=%b rd=%b valid=%b count=%0d pc=%h addr=%0d, expected all zero",
                     fetchErrA, readEnA, ifValidA, fetchCountA, ifPcA, insAddrA);
        end
        @(negedge CLK) rstA_n = 1'b1;
        pushExp(32'h0, 32'd1, 1'b1, 32'd1);
        repeat (2) @(posedge CLK);
        #1;
        e = sbq.pop_front();
        checks++;
        if (gotA !== e) begin
            errors++;
            $display("[TB] FAIL reboot_fetch: got %h, expected %h", gotA, e);
        end
    endtask

    task automatic test_range_end;
        bit done = 1'b0;
        for (int i = 0; i < 16; i++) pushExp(32'(4 * i), 32'(i + 1), 1'b1, 32'(i + 1));
        @(negedge CLK) rstB_n = 1'b1;
        for (int c = 0; c < 40 && !done; c++) begin
            @(posedge CLK); #1;
            if (ifValidB) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL range_extra: got %h, expected no further instruction", gotB);
                end else begin
                    e = sbq.pop_front();
                    if (gotB !== e) begin
                        errors++;
                        $display("[TB] FAIL range_seq: got %h, expected %h", gotB, e);
                    end
                end
            end
            if (fetchErrB) done = 1'b1;
        end
        checks++;
        if (!done || sbq.size() != 0 || fetchCountB !== 32'd16 || readEnB !== 1'b0) begin
            errors++;
            $display("[TB] FAIL range_trap: got trapped=%b left=%0d count=%0d rd=%b, expected trapped=1 left=0 count=16 rd=0",
                     done, sbq.size(), fetchCountB, readEnB);
        end
        @(posedge CLK); #1;
        checks++;
        if ({ifValidB, ifInstrB, fetchErrB, readEnB, ifPcB} !== {1'b0, 32'h13, 1'b1, 1'b0, 32'h3C}) begin
            errors++;
            $display("[TB] FAIL range_after: got valid=%b instr=%h err=%b rd=%b pc=%h, expected 0/13/1/0/3c",
                     ifValidB, ifInstrB, fetchErrB, readEnB, ifPcB);
        end
    endtask

    initial begin
        rstB_n = 1'b0; stallB = 1'b0; branchB = 1'b0; targetB = 32'd0;
        test_reset;
        test_stall;
        test_redirect;
        test_branch_during_stall;
        test_misaligned;
        test_range_end;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
